// File: rtl/apb_completer_regfile_pkg.sv
// Shared types and address-map helpers for the APB completer register file.
// Also holds the default ID constant and the APB bus widths.
package apb_pkg;

  localparam int APB_DW = 32;
  localparam int APB_AW = 32;

  localparam logic [APB_DW-1:0] DEFAULT_ID_VALUE = 32'hA9B0_0001;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  // The two read-only registers sit directly above the RW bank.
  function automatic logic [APB_AW-1:0] idOff(input int numRegs);
    return APB_AW'(numRegs * 4);
  endfunction

  function automatic logic [APB_AW-1:0] wcntOff(input int numRegs);
    return APB_AW'(numRegs * 4 + 4);
  endfunction

endpackage

// File: rtl/apb_completer_regfile_if.sv
// APB bus bundle between the bridge's controller (master) and a completer (slave).
interface apb_completer_regfile_if;
  import apb_pkg::*;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [APB_AW-1:0] paddr;
  logic [APB_DW-1:0] pwdata;
  logic [APB_DW-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_completer_regfile_wait_gen.sv
// Wait-state generator: loads a fixed count at the setup edge, counts down through
// the access phase and raises a registered ready. readyNext_o lets the owner align pslverr.
module apb_wait_gen #(
  parameter int WAIT_STATES = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic step_i,
  input  logic clear_i,
  output logic ready_o,
  output logic readyNext_o
);

  logic [3:0] cnt_q, cnt_d;
  logic       ready_q, ready_d;

  always_comb begin
    cnt_d   = cnt_q;
    ready_d = ready_q;
    if (load_i) begin
      cnt_d   = 4'(WAIT_STATES);
      ready_d = (WAIT_STATES == 0);
    end else if (step_i) begin
      cnt_d   = cnt_q - 4'd1;
      ready_d = (cnt_q == 4'd1);
    end else if (clear_i) begin
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign ready_o     = ready_q;
  assign readyNext_o = ready_d;

endmodule

// File: rtl/apb_completer_regfile.sv
// APB completer with NUM_REGS RW registers, an ID register and a committed-write counter.
// Address, direction and write data are captured at the setup edge; writes commit on completion.
module apb_completer_regfile
  import apb_pkg::*;
#(
  parameter int                NUM_REGS    = 8,
  parameter int                WAIT_STATES = 0,
  parameter logic [APB_DW-1:0] ID_VALUE    = DEFAULT_ID_VALUE
) (
  input  logic                       hclk,
  input  logic                       hreset,
  apb_completer_regfile_if.slave     apb,
  output logic [NUM_REGS*APB_DW-1:0] reg_q
);

  localparam int                IW       = $clog2(NUM_REGS);
  localparam logic [APB_AW-1:0] ID_OFF   = idOff(NUM_REGS);
  localparam logic [APB_AW-1:0] WCNT_OFF = wcntOff(NUM_REGS);

  state_e            state_q, state_d;
  logic [APB_DW-1:0] regs_q [NUM_REGS];
  logic [APB_DW-1:0] wcnt_q, wcnt_d;
  logic [APB_DW-1:0] prdata_q, prdata_d;
  logic              pslverr_q, pslverr_d;
  logic [APB_DW-1:0] wdata_q;
  logic [IW-1:0]     idx_q;
  logic              write_q, err_q;

  logic              setup, step, complete, abort, commit;
  logic              setupErr, readyQ, readyNext;
  logic [APB_DW-1:0] rdValue;

  always_comb begin
    setupErr = (apb.paddr[1:0] != 2'b00) || (apb.paddr > WCNT_OFF) ||
               (apb.pwrite && ((apb.paddr == ID_OFF) || (apb.paddr == WCNT_OFF)));
    rdValue  = '0;
    if (apb.paddr < ID_OFF)        rdValue = regs_q[apb.paddr[IW+1:2]];
    else if (apb.paddr == ID_OFF)  rdValue = ID_VALUE;
    else if (apb.paddr == WCNT_OFF) rdValue = wcnt_q;
  end

  always_comb begin
    state_d  = state_q;
    setup    = 1'b0;
    step     = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: begin
        if (apb.psel && !apb.penable) begin
          setup   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!apb.psel) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (apb.penable) begin
          if (readyQ) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            step = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign commit = complete && write_q && !err_q;

  // pslverr follows the ready that is about to be registered so it never leads pready.
  always_comb begin
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    wcnt_d    = wcnt_q;
    if (setup) begin
      pslverr_d = setupErr && readyNext;
      if (!apb.pwrite) prdata_d = setupErr ? '0 : rdValue;
    end else if (step) begin
      pslverr_d = err_q && readyNext;
    end else if (complete || abort) begin
      pslverr_d = 1'b0;
    end
    if (commit) wcnt_d = wcnt_q + 32'd1;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= IDLE;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      wcnt_q    <= '0;
      wdata_q   <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      wcnt_q    <= wcnt_d;
      if (setup) begin
        wdata_q <= apb.pwdata;
        idx_q   <= apb.paddr[IW+1:2];
        write_q <= apb.pwrite;
        err_q   <= setupErr;
      end
      if (commit) regs_q[idx_q] <= wdata_q;
    end
  end

  apb_wait_gen #(
    .WAIT_STATES(WAIT_STATES)
  ) u_wait_gen (
    .clk_i      (hclk),
    .rst_i      (hreset),
    .load_i     (setup),
    .step_i     (step),
    .clear_i    (complete || abort),
    .ready_o    (readyQ),
    .readyNext_o(readyNext)
  );

  for (genvar g = 0; g < NUM_REGS; g++) begin : gFlat
    assign reg_q[g*APB_DW +: APB_DW] = regs_q[g];
  end

  assign apb.prdata  = prdata_q;
  assign apb.pready  = readyQ;
  assign apb.pslverr = pslverr_q;

endmodule
